// File: rtl/digit_serial_add_sub_pkg.sv
// Shared types and default sizing for the digit-serial add/subtract block.
package serial_arith_pkg;

    localparam int DEFAULT_DIGIT_W     = 1;
    localparam int DEFAULT_WORD_DIGITS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/digit_serial_add_sub_if.sv
// Digit stream bus: operand digits in, result digits plus word flags out.
interface digit_serial_add_sub_if
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W = DEFAULT_DIGIT_W
);

    logic               in_valid;
    logic               in_first;
    logic               in_sub;
    logic [DIGIT_W-1:0] in_a;
    logic [DIGIT_W-1:0] in_b;
    logic               out_valid;
    logic [DIGIT_W-1:0] out_sum;
    logic               out_last;
    logic               out_carry;
    logic               out_ovf;

    modport master (
        output in_valid, in_first, in_sub, in_a, in_b,
        input  out_valid, out_sum, out_last, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_first, in_sub, in_a, in_b,
        output out_valid, out_sum, out_last, out_carry, out_ovf
    );

endinterface

// File: rtl/digit_serial_add_sub_fa_cell.sv
// One-bit full adder built from plain XOR/AND/OR gates.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: LSD-first words, one digit per valid cycle,
// carry kept between digits, word flags reported with the final digit.
module digit_serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int DIGIT_W     = DEFAULT_DIGIT_W,
    parameter int WORD_DIGITS = DEFAULT_WORD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digit_serial_add_sub_if.slave bus
);

    localparam int            CW       = $clog2(WORD_DIGITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_DIGITS - 1);

    state_t             state, state_n;
    logic [CW-1:0]      cnt_p1, cnt_n, cnt_cur;
    logic               carry_p1, carry_n;
    logic               mode_p1, mode_n;
    logic               accept, last, cin, mode_cur;
    logic [DIGIT_W-1:0] b_eff, sum;
    logic [DIGIT_W:0]   c;

    // Ripple chain: c[0] is the digit carry-in, c[DIGIT_W] carries to the next digit.
    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
        fa_cell u_fa (
            .a    (bus.in_a[i]),
            .b    (b_eff[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    // Next-state and next-datapath logic; in_first restarts the word from any state.
    always_comb begin
        accept   = bus.in_valid && (bus.in_first || state == RUN);
        cin      = bus.in_first ? bus.in_sub : carry_p1;
        mode_cur = bus.in_first ? bus.in_sub : mode_p1;
        cnt_cur  = bus.in_first ? '0 : cnt_p1;
        b_eff    = bus.in_b ^ {DIGIT_W{mode_cur}};
        last     = accept && (cnt_cur == LAST_CNT);
        state_n  = state;
        cnt_n    = cnt_p1;
        carry_n  = carry_p1;
        mode_n   = mode_p1;
        if (accept) begin
            state_n = last ? IDLE : RUN;
            cnt_n   = last ? '0 : cnt_cur + CW'(1);
            carry_n = c[DIGIT_W];
            mode_n  = mode_cur;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Word-progress registers and the registered result digit with its flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1        <= '0;
            carry_p1      <= 1'b0;
            mode_p1       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_carry <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end else begin
            cnt_p1        <= cnt_n;
            carry_p1      <= carry_n;
            mode_p1       <= mode_n;
            bus.out_valid <= accept;
            bus.out_sum   <= accept ? sum : '0;
            bus.out_last  <= last;
            bus.out_carry <= last & c[DIGIT_W];
            bus.out_ovf   <= last & (c[DIGIT_W] ^ c[DIGIT_W-1]);
        end
    end

endmodule

// File: doc/digit_serial_add_sub.md
DIGIT_SERIAL_ADD_SUB -- requirements
Module: digit_serial_add_sub

Interface
REQ-001 Parameter DIGIT_W, default 1: bits processed per valid cycle, legal range 1..16.
REQ-002 Parameter WORD_DIGITS, default 8: digits per word, legal range 2..64; word width is DIGIT_W*WORD_DIGITS.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous reset, active-low.
REQ-005 Port in_valid, input, 1: in_a/in_b/in_first/in_sub carry a valid digit this cycle.
REQ-006 Port in_first, input, 1: digit is the least-significant digit of a new word.
REQ-007 Port in_sub, input, 1: operation select, sampled only with in_first; 1 = a-b, 0 = a+b.
REQ-008 Port in_a, input, DIGIT_W: operand A digit, LSD first.
REQ-009 Port in_b, input, DIGIT_W: operand B digit, LSD first.
REQ-010 Port out_valid, output, 1: out_sum holds a result digit.
REQ-011 Port out_sum, output, DIGIT_W: result digit.
REQ-012 Port out_last, output, 1: out_sum is the most-significant digit of the word.
REQ-013 Port out_carry, output, 1: word carry-out (add) or not-borrow (sub); valid only with out_last.
REQ-014 Port out_ovf, output, 1: two's-complement signed overflow of the word; valid only with out_last.

Function
REQ-015 Latency SHALL be exactly one cycle: every output is registered and reflects the digit accepted on the previous edge.
REQ-016 The FSM SHALL have states IDLE and RUN; IDLE->RUN on in_valid&in_first; RUN->IDLE on the accepted digit that completes WORD_DIGITS digits.
REQ-017 In IDLE, digits with in_valid=1 and in_first=0 SHALL be ignored: out_valid=0, no state change.
REQ-018 A digit counter SHALL load 1 on in_first and increment per accepted digit, wrapping to 0 at WORD_DIGITS.
REQ-019 Cycles with in_valid=0 SHALL hold counter, carry, mode and FSM state, and drive out_valid=0.
REQ-020 On in_first the carry-in SHALL be in_sub, and mode SHALL latch in_sub for the rest of the word.
REQ-021 In subtract mode each B bit SHALL be inverted before addition.
REQ-022 Digit sum SHALL be a DIGIT_W-bit ripple of full-adder cells using only XOR/AND/OR/NOT; the final carry SHALL be stored for the next digit.
REQ-023 out_last SHALL be 1 on the WORD_DIGITS-th digit only; out_carry = carry out of its MSB; out_ovf = carry into MSB XOR carry out of MSB.
REQ-024 out_carry and out_ovf SHALL be 0 whenever out_last=0.
REQ-025 in_first asserted in RUN (mid-word) SHALL abort the current word without out_last and start a new word with this digit.
REQ-026 in_first on the digit that also completes a word SHALL be treated as REQ-025.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counter 0, carry 0, mode 0, and out_valid, out_sum, out_last, out_carry, out_ovf to 0.
REQ-028 Reset mid-word SHALL discard the word; the first accepted digit after release SHALL require in_first.

Structure
REQ-029 Package serial_arith_pkg SHALL hold the FSM state enum and default values for DIGIT_W and WORD_DIGITS.
REQ-030 One sub-module, fa_cell (1-bit full adder: a, b, cin -> s, cout), SHALL be instantiated DIGIT_W times.
REQ-031 Counter width SHALL be $clog2(WORD_DIGITS+1).

Verification
REQ-032 DIGIT_W=1, WORD_DIGITS=8, add 0x5A+0x33 over 8 back-to-back digits -> 8 out_valid pulses forming 0x8D, out_last on 8th, out_carry=0, out_ovf=1.
REQ-033 Same config, sub 0x10-0x20 -> result 0xF0, out_carry=0, out_ovf=0; then add 0xFF+0x01 -> 0x00, out_carry=1, out_ovf=0.
REQ-034 DIGIT_W=4, WORD_DIGITS=2, add 0x7F+0x01 with in_valid low for 3 cycles between digits -> 0x80, out_carry=0, out_ovf=1, no out_valid during gaps.
REQ-035 DIGIT_W=1: in_first reasserted after 5 digits, then 8 digits of 0x03+0x04 -> no out_last for the aborted word, then 0x07 with out_last.
REQ-036 rst_n pulsed low mid-cycle during digit 4 -> all outputs 0 immediately; digits without in_first ignored until next in_first.
